bit_population_decoder: RTL

- Inverse of the bit population counter: takes a population count N and produces a WIDTH-bit thermometer mask with exactly N low-order bits set.
- Sits where a count must be expanded back to a bit mask (byte enables, lane masks, round-trip self-check against the population counter).
- Fully pipelined, one result per clock, no backpressure; same valid-qualified streaming style as the counter.

---
 rtl/bit_population_decoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bit_population_decoder.sv
// bit_population_decoder
// Expands a population count N into a WIDTH-bit thermometer mask with the
// N low-order bits set. Fully pipelined, one result per clock, no
// backpressure. Counts above WIDTH saturate to all ones and raise an
// overflow flag that travels with the word.
//
// Optional feature: define BIT_POP_DECODER_ROTATE_EN to add the rot_i port
// and one extra register stage that rotates the finished mask left by
// rot_i mod WIDTH.
module bit_population_decoder #(
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic [$clog2(WIDTH):0]   data_i,
   input  logic                     data_val_i,
`ifdef BIT_POP_DECODER_ROTATE_EN
   input  logic [$clog2(WIDTH)-1:0] rot_i,
`endif
   output logic [WIDTH-1:0]         data_o,
   output logic                     data_val_o,
   output logic                     data_ovf_o
);

   localparam int            CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);

   // Mask with the n lowest bits set; n may reach or exceed WIDTH.
   function automatic logic [WIDTH-1:0] low_ones(input int n);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = (i < n);
      end
      return r;
   endfunction

   // Index 0 is the input register, indices 1..CW are the build stages.
   // mask_q[0] is permanently zero: the mask entering stage 1 is empty.
   logic [CW-1:0]    cnt_q  [0:CW];
   logic [WIDTH-1:0] mask_q [0:CW];
   logic             val_q  [0:CW];
   logic             ovf_q  [0:CW];

`ifdef BIT_POP_DECODER_ROTATE_EN
   localparam int RW = $clog2(WIDTH);

   logic [RW-1:0]    rot_q [0:CW];
   logic [WIDTH-1:0] rot_mask_q;
   logic             rot_val_q;
   logic             rot_ovf_q;

   // rot_i is below 2*WIDTH, so one conditional subtraction gives the modulo.
   function automatic logic [WIDTH-1:0] rotate_left(input logic [WIDTH-1:0] m,
                                                    input logic [RW-1:0]    r);
      int amt;
      amt = int'(r);
      if (amt >= WIDTH) begin
         amt = amt - WIDTH;
      end
      return (m << amt) | (m >> (WIDTH - amt));
   endfunction
`endif

   // Input capture with saturation, then one build stage per count bit:
   // stage k shifts the mask up by 2^(k-1) and fills the vacated low bits.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int k = 0; k <= CW; k++) begin
            cnt_q[k]  <= '0;
            mask_q[k] <= '0;
            val_q[k]  <= 1'b0;
            ovf_q[k]  <= 1'b0;
`ifdef BIT_POP_DECODER_ROTATE_EN
            rot_q[k]  <= '0;
`endif
         end
      end else begin
         val_q[0]  <= data_val_i;
         mask_q[0] <= '0;
         if (data_val_i) begin
            if (data_i > WIDTH_CNT) begin
               cnt_q[0] <= WIDTH_CNT;
               ovf_q[0] <= 1'b1;
            end else begin
               cnt_q[0] <= data_i;
               ovf_q[0] <= 1'b0;
            end
`ifdef BIT_POP_DECODER_ROTATE_EN
            rot_q[0] <= rot_i;
`endif
         end
         for (int k = 1; k <= CW; k++) begin
            val_q[k] <= val_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
            cnt_q[k] <= cnt_q[k-1];
`ifdef BIT_POP_DECODER_ROTATE_EN
            rot_q[k] <= rot_q[k-1];
`endif
            if (cnt_q[k-1][k-1]) begin
               mask_q[k] <= (mask_q[k-1] << (1 << (k - 1))) | low_ones(1 << (k - 1));
            end else begin
               mask_q[k] <= mask_q[k-1];
            end
         end
      end
   end

`ifdef BIT_POP_DECODER_ROTATE_EN
   // Extra stage rotating the completed mask left by the captured amount.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rot_mask_q <= '0;
         rot_val_q  <= 1'b0;
         rot_ovf_q  <= 1'b0;
      end else begin
         rot_mask_q <= rotate_left(mask_q[CW], rot_q[CW]);
         rot_val_q  <= val_q[CW];
         rot_ovf_q  <= ovf_q[CW];
      end
   end

   assign data_val_o = rot_val_q;
   assign data_o     = rot_val_q ? rot_mask_q : '0;
   assign data_ovf_o = rot_val_q & rot_ovf_q;
`else
   assign data_val_o = val_q[CW];
   assign data_o     = val_q[CW] ? mask_q[CW] : '0;
   assign data_ovf_o = val_q[CW] & ovf_q[CW];
`endif

endmodule
